// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the buffered UART transmitter.
//               Holds the serialiser state encoding, default parameter values
//               and a helper that returns the length of one frame in clocks.
//               The PARITY state and parity bit count exist only when
//               UART_TX_PARITY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;   // 100 MHz / 115200 baud
    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_FIFO_DEPTH   = 16;
    localparam int DEFAULT_STOP_BITS    = 1;

`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Serialiser states. PARITY is encoded last so the other codes do not
    // move between builds with and without parity.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } tx_state_e;

    // Clock cycles occupied by one complete frame on the serial line.
    function automatic int frame_len(input int clks_per_bit,
                                     input int data_width,
                                     input int stop_bits);
        return (1 + data_width + PARITY_BITS + stop_bits) * clks_per_bit;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered pointers and occupancy.
//               Pushes while full and pops while empty are ignored. Pointers
//               wrap modulo DEPTH (DEPTH must be a power of two, >= 2). The
//               read port is combinational from the head entry, so dout_o is
//               valid whenever empty_o is low.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push_i, din_i - write request and data
//               pop_i         - read request (consumes dout_o)
//               dout_o        - head entry
//               full_o, empty_o, level_o - occupancy status
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      level_q;
    logic [AW:0]      level_d;
    logic             w_push;
    logic             w_pop;

    // Requests are qualified with the pre-edge flags, so a push while full
    // is dropped even if a pop frees an entry on the same edge.
    always_comb begin
        w_push  = push_i && !full_o;
        w_pop   = pop_i && !empty_o;
        level_d = level_q;
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Storage carries no reset; a flush only needs the pointers cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_buffered
// Description : Buffered UART transmitter. Words written by the CPU are
//               queued in a sync_fifo and serialised LSB first as
//               start / data / [parity] / stop frames on uart_tx_o. When a
//               frame's last stop cycle coincides with a non-empty FIFO the
//               next word is popped on that edge, so frames run back to back.
//               Build option: define UART_TX_PARITY_EN to insert a parity bit
//               (even, or odd when PARITY_ODD=1) after the data bits.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               wr_en_i      - push wr_data_i into the FIFO
//               wr_data_i    - word to transmit
//               ovf_clr_i    - clear the sticky overflow flag
//               full_o       - FIFO full, a write now is dropped
//               empty_o      - FIFO empty
//               level_o      - FIFO occupancy
//               overflow_o   - sticky: a write was dropped
//               busy_o       - frame in progress or data queued
//               uart_tx_o    - serial line, idle high, registered
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
    parameter int STOP_BITS    = DEFAULT_STOP_BITS,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          ovf_clr_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic                          uart_tx_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if ((CLKS_PER_BIT < 2) || (DATA_WIDTH < 5) || (DATA_WIDTH > 9) ||
        ((STOP_BITS != 1) && (STOP_BITS != 2)) ||
        (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
        $error("uart_tx_buffered: illegal parameter value");
    end

    tx_state_e               state_q;
    logic [BAUD_W-1:0]       baud_q;
    logic [BIT_W-1:0]        bit_q;      // data bit index, reused for stop bits
    logic [DATA_WIDTH-1:0]   shift_q;
    logic                    tx_q;
    logic                    ovf_q;
    logic                    ovf_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q;
`endif

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_dout;
    logic                    w_baud_last;
    logic                    w_stop_done;
    logic                    w_pop;

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (wr_en_i),
        .din_i   (wr_data_i),
        .pop_i   (w_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level_o)
    );

    // The serialiser takes a new word either from IDLE or on the very last
    // stop cycle, which removes any idle gap between queued frames.
    always_comb begin
        w_baud_last = (baud_q == BAUD_LAST);
        w_stop_done = (state_q == STOP) && w_baud_last && (bit_q == STOP_LAST);
        w_pop       = !fifo_empty && ((state_q == IDLE) || w_stop_done);
    end

    // A dropped write sets the flag even when a clear arrives with it.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (wr_en_i && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else if (w_pop) begin
            // Load takes priority: the start bit goes out on this edge.
            state_q <= START;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= fifo_dout;
            tx_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= (^fifo_dout) ^ (PARITY_ODD != 0);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    tx_q   <= 1'b1;
                end

                START: begin
                    if (w_baud_last) begin
                        state_q <= DATA;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        baud_q  <= baud_q + BAUD_W'(1);
                    end
                end

                DATA: begin
                    if (w_baud_last) begin
                        baud_q <= '0;
                        if (bit_q == DATA_LAST) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= par_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_baud_last) begin
                        state_q <= STOP;
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= 1'b1;
                    end else begin
                        baud_q  <= baud_q + BAUD_W'(1);
                    end
                end
`endif

                STOP: begin
                    tx_q <= 1'b1;
                    if (w_baud_last) begin
                        baud_q <= '0;
                        if (bit_q == STOP_LAST) begin
                            // Queue empty here, otherwise w_pop took over.
                            state_q <= IDLE;
                            bit_q   <= '0;
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    baud_q  <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign full_o     = fifo_full;
    assign empty_o    = fifo_empty;
    assign overflow_o = ovf_q;
    assign busy_o     = (state_q != IDLE) || !fifo_empty;
    assign uart_tx_o  = tx_q;

endmodule : uart_tx_buffered
`default_nettype wire
